// File: rtl/ram_rr_arbiter_if.sv
// Requester-side bundle for ram_rr_arbiter: req/gnt handshake plus routed read return.
// master = requester, slave = arbiter.
interface ram_rr_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
);
  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] di;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (output req, we, addr, di, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, di, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin front end for one single-port block RAM, with tagged read return.
// Optional macro RAM_RR_ARBITER_OUTREG_EN adds a RAM output register (read latency 1 -> 2).
module ram_rr_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_rr_arbiter_if.slave  a,
  ram_rr_arbiter_if.slave  b,
  output logic             busy
);

`ifdef RAM_RR_ARBITER_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e             r_rr_ptr, w_rr_nxt;
  logic              w_a_gnt, w_b_gnt;
  logic              w_xfer, w_we, w_rd;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_di;
  logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];
  logic [DWIDTH-1:0] r_do, w_ram_q;
  logic [STAGES-1:0] r_tag_vld, r_tag_own;
  logic [DWIDTH-1:0] r_a_hold, r_b_hold;
  logic              w_a_rv, w_b_rv;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_a_gnt  = rst_n & a.req & (~b.req | (r_rr_ptr == PORT_A));
    w_b_gnt  = rst_n & b.req & (~a.req | (r_rr_ptr == PORT_B));
    w_rr_nxt = r_rr_ptr;
    if (w_a_gnt)      w_rr_nxt = PORT_B;
    else if (w_b_gnt) w_rr_nxt = PORT_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rr_ptr <= PORT_A;
    else        r_rr_ptr <= w_rr_nxt;
  end

  always_comb begin
    w_xfer = w_a_gnt | w_b_gnt;
    w_we   = w_a_gnt ? a.we   : b.we;
    w_addr = w_a_gnt ? a.addr : b.addr;
    w_di   = w_a_gnt ? a.di   : b.di;
    w_rd   = w_xfer & ~w_we;
  end

  // Plain RAM process, no reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_xfer && w_we) r_mem[w_addr] <= w_di;
    if (w_rd)           r_do <= r_mem[w_addr];
  end

`ifdef RAM_RR_ARBITER_OUTREG_EN
  logic [DWIDTH-1:0] r_do_q;
  always_ff @(posedge clk) r_do_q <= r_do;
  assign w_ram_q = r_do_q;
`else
  assign w_ram_q = r_do;
`endif

  // Tag pipeline tracks owner of each read so data returns to the issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= w_rd;
      r_tag_own[0] <= w_b_gnt;
      for (int i = 1; i < STAGES; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign w_a_rv = r_tag_vld[STAGES-1] & ~r_tag_own[STAGES-1];
  assign w_b_rv = r_tag_vld[STAGES-1] &  r_tag_own[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_hold <= '0;
      r_b_hold <= '0;
    end else begin
      if (w_a_rv) r_a_hold <= w_ram_q;
      if (w_b_rv) r_b_hold <= w_ram_q;
    end
  end

  assign a.gnt    = w_a_gnt;
  assign b.gnt    = w_b_gnt;
  assign a.rvalid = w_a_rv;
  assign b.rvalid = w_b_rv;
  assign a.rdata  = w_a_rv ? w_ram_q : r_a_hold;
  assign b.rdata  = w_b_rv ? w_ram_q : r_b_hold;
  assign busy     = |r_tag_vld;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: transaction-level model (memory array + pending-read queue)
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ram_rr_arbiter;
`ifdef RAM_RR_ARBITER_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk, rst_n, busy;
  ram_rr_arbiter_if #(.DWIDTH(16), .AWIDTH(7)) a_if ();
  ram_rr_arbiter_if #(.DWIDTH(16), .AWIDTH(7)) b_if ();

  ram_rr_arbiter #(.DWIDTH(16), .AWIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .a(a_if), .b(b_if), .busy(busy));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; bit own_b; logic [15:0] data; } rd_t;
  rd_t         q[$];
  logic [15:0] m_mem [128];
  bit          m_ptr_b;
  logic [15:0] m_hold_a, m_hold_b;
  int          cyc = 0;

  always @(negedge clk) begin
    bit eg_a, eg_b, ev_a, ev_b, pop;
    cyc++;
    if (!rst_n) begin
      chk("rst_gnt_a", a_if.gnt, 0);       chk("rst_gnt_b", b_if.gnt, 0);
      chk("rst_rvalid_a", a_if.rvalid, 0); chk("rst_rvalid_b", b_if.rvalid, 0);
      chk("rst_rdata_a", a_if.rdata, 0);   chk("rst_rdata_b", b_if.rdata, 0);
      chk("rst_busy", busy, 0);
      q.delete(); m_ptr_b = 0; m_hold_a = '0; m_hold_b = '0;
    end else begin
      // Single requester wins outright; contention goes to whoever the pointer names.
      eg_a = a_if.req && (!b_if.req || !m_ptr_b);
      eg_b = b_if.req && (!a_if.req ||  m_ptr_b);
      chk("gnt_a", a_if.gnt, eg_a);
      chk("gnt_b", b_if.gnt, eg_b);
      ev_a = 0; ev_b = 0; pop = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        pop = 1;
        if (q[0].own_b) begin ev_b = 1; m_hold_b = q[0].data; end
        else            begin ev_a = 1; m_hold_a = q[0].data; end
      end
      chk("rvalid_a", a_if.rvalid, ev_a);
      chk("rvalid_b", b_if.rvalid, ev_b);
      chk("rdata_a", a_if.rdata, m_hold_a);
      chk("rdata_b", b_if.rdata, m_hold_b);
      chk("busy", busy, q.size() > 0);
      if (pop) void'(q.pop_front());
      if (eg_a) begin
        if (a_if.we) m_mem[a_if.addr] = a_if.di;
        else q.push_back('{due: cyc + L, own_b: 0, data: m_mem[a_if.addr]});
        m_ptr_b = 1;
      end else if (eg_b) begin
        if (b_if.we) m_mem[b_if.addr] = b_if.di;
        else q.push_back('{due: cyc + L, own_b: 1, data: m_mem[b_if.addr]});
        m_ptr_b = 0;
      end
    end
  end

  // Return capture used by the literal ordering checks.
  logic [15:0] ra_q[$], rb_q[$];
  always @(negedge clk) begin
    if (a_if.rvalid) ra_q.push_back(a_if.rdata);
    if (b_if.rvalid) rb_q.push_back(b_if.rdata);
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic drv_a(input bit r, input bit w, input logic [6:0] ad, input logic [15:0] d);
    a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.di = d;
  endtask
  task automatic drv_b(input bit r, input bit w, input logic [6:0] ad, input logic [15:0] d);
    b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.di = d;
  endtask

  initial begin
    logic [6:0] ia, ib;
    bit ga, gb, seen;
    int lat;
    logic [15:0] exp_a[3], exp_b[3];
    rst_n = 1'b0;
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;

    // preload whole RAM: addr i holds 0x1000+i
    for (int i = 0; i < 128; i++) begin
      drv_a(1, 1, 7'(i), 16'h1000 + 16'(i)); step();
    end
    drv_a(0, 0, 0, 0); step();

    // write then read A 0x05
    drv_a(1, 1, 7'h05, 16'h1234); @(negedge clk); chk("t1_wr_gnt", a_if.gnt, 1); step();
    drv_a(1, 0, 7'h05, 0);        @(negedge clk); chk("t1_rd_gnt", a_if.gnt, 1); step();
    drv_a(0, 0, 0, 0);
    repeat (L - 1) step();
    @(negedge clk);
    chk("t1_rvalid_a", a_if.rvalid, 1); chk("t1_rdata_a", a_if.rdata, 16'h1234);
    chk("t1_rvalid_b", b_if.rvalid, 0);
    step();

    // rr_ptr is B now: lone B for 4 cycles, every one granted
    for (int k = 0; k < 4; k++) begin
      drv_b(1, 0, 7'h20 + 7'(k), 0); @(negedge clk); chk("t3_b_gnt", b_if.gnt, 1); step();
    end
    drv_b(0, 0, 0, 0);
    repeat (L + 1) step();

    // both held: alternation A,B,A,B,A,B starting with A
    ra_q.delete(); rb_q.delete();
    ia = 7'h01; ib = 7'h10;
    for (int k = 0; k < 6; k++) begin
      drv_a(1, 0, ia, 0); drv_b(1, 0, ib, 0);
      @(negedge clk);
      ga = a_if.gnt; gb = b_if.gnt;
      chk("t2_gnt_a", ga, (k % 2) == 0); chk("t2_gnt_b", gb, (k % 2) == 1);
      step();
      if (ga) ia++;
      if (gb) ib++;
    end
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    repeat (L + 1) step();
    exp_a = '{16'h1001, 16'h1002, 16'h1003};
    exp_b = '{16'h1010, 16'h1011, 16'h1012};
    chk("t2_a_count", ra_q.size(), 3); chk("t2_b_count", rb_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < ra_q.size()) chk("t2_a_data", ra_q[k], exp_a[k]);
      if (k < rb_q.size()) chk("t2_b_data", rb_q[k], exp_b[k]);
    end

    // B writes 0x7F, A reads it the next cycle
    drv_b(1, 1, 7'h7F, 16'hBEEF); step();
    drv_b(0, 0, 0, 0); drv_a(1, 0, 7'h7F, 0);
    @(negedge clk); chk("t4_rd_gnt", a_if.gnt, 1); step();
    drv_a(0, 0, 0, 0);
    repeat (L - 1) step();
    @(negedge clk);
    chk("t4_rvalid_a", a_if.rvalid, 1); chk("t4_rdata_a", a_if.rdata, 16'hBEEF);
    step();

    // read in flight, then reset before it returns
    drv_b(1, 0, 7'h33, 0); step();      // leaves rr_ptr at A
    drv_b(0, 0, 0, 0);
    repeat (L + 1) step();
    drv_a(1, 0, 7'h05, 0); step();
    drv_a(0, 0, 0, 0); rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); if (a_if.rvalid) seen = 1;
      if (k == 0) begin chk("t5_rdata_a", a_if.rdata, 0); chk("t5_busy", busy, 0); end
      step();
    end
    chk("t5_no_rvalid", seen, 0);
    drv_a(1, 0, 7'h01, 0); drv_b(1, 0, 7'h02, 0);
    @(negedge clk); chk("t5_gnt_a", a_if.gnt, 1); chk("t5_gnt_b", b_if.gnt, 0); step();
    drv_a(0, 0, 0, 0);
    @(negedge clk); chk("t5_gnt_b2", b_if.gnt, 1); step();
    drv_b(0, 0, 0, 0);
    repeat (L + 1) step();

    // latency measurement on 0x00 <= 0xA5A5
    drv_a(1, 1, 7'h00, 16'hA5A5); step();
    drv_a(1, 0, 7'h00, 0); step();
    drv_a(0, 0, 0, 0);
    lat = 0; seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (a_if.rvalid) begin
        seen = 1; lat = k;
        chk("t6_rdata", a_if.rdata, 16'hA5A5);
      end
      step();
    end
    chk("t6_rvalid_seen", seen, 1);
    chk("t6_latency", lat, L);

    // random protocol-compliant traffic
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); ga = a_if.gnt; gb = b_if.gnt;
      step();
      if (k == 1500) rst_n = 1'b0;
      if (k == 1503) rst_n = 1'b1;
      if (!a_if.req || ga)
        drv_a($urandom_range(3) != 0, $urandom_range(1), 7'($urandom), 16'($urandom));
      if (!b_if.req || gb)
        drv_b($urandom_range(3) != 0, $urandom_range(1), 7'($urandom), 16'($urandom));
    end
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    repeat (L + 2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
